wb_trace_buffer: RTL and testbench

//   Synthesizable write-back trace capture for the datapath.

---
 rtl/wb_trace_buffer.sv | 145 ++++++++++++++
 tb/tb_wb_trace_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: write-back trace capture.
// Records every architectural register write (rd, value, cycle stamp) seen on
// the write-back bus during a bounded capture window into a FWFT FIFO that is
// drained over a valid/ready port.
// Optional feature macro: TRACE_FILTER_EN adds a per-register trace_mask input.
module wb_trace_buffer #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 16,
  parameter int CYCLE_W    = 16,
  parameter int RUN_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     wb_en,
  input  logic [REG_ADDR_W-1:0]    wb_rd,
  input  logic [XLEN-1:0]          wb_data,
`ifdef TRACE_FILTER_EN
  input  logic [2**REG_ADDR_W-1:0] trace_mask,
`endif
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [REG_ADDR_W-1:0]    rd_reg,
  output logic [XLEN-1:0]          rd_data,
  output logic [CYCLE_W-1:0]       rd_cycle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy,
  output logic                     done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = CYCLE_W + REG_ADDR_W + XLEN;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CYCLE_W-1:0]   cyc_q, cyc_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [ENT_W-1:0]     mem_q [DEPTH];

  logic last_cyc, enter_run, mask_ok, push_req, push, pop, full;
  logic [ENT_W-1:0] head;

  // Final window cycle; a zero window never ends on its own.
  assign last_cyc = (RUN_CYCLES != 0) && (cyc_q == CYCLE_W'(RUN_CYCLES - 1));

`ifdef TRACE_FILTER_EN
  assign mask_ok = trace_mask[wb_rd];
`else
  assign mask_ok = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_cyc) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    enter_run = (state_q != S_RUN) && (state_d == S_RUN);
  end

  // Push/pop qualification. A push into a full FIFO only lands if a pop frees
  // the head slot on the same edge; x0 writes are never traced.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    rd_valid = (count_q != '0);
    pop      = rd_valid && rd_ready;
    push_req = busy && wb_en && (wb_rd != '0) && mask_ok;
    push     = push_req && (!full || pop);
  end

  // Next-state for cycle stamp, pointers, occupancy and the sticky overflow.
  always_comb begin
    cyc_d = cyc_q;
    if (enter_run)                 cyc_d = '0;
    else if (busy && cyc_q != '1)  cyc_d = cyc_q + 1'b1;

    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (enter_run)                     overflow_d = 1'b0;
    else if (push_req && full && !pop) overflow_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cyc_q      <= cyc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; stale data is masked by rd_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {cyc_q, wb_rd, wb_data};
  end

  // FWFT head, forced to zero while empty.
  always_comb begin
    head     = rd_valid ? mem_q[rptr_q] : '0;
    rd_cycle = head[ENT_W-1 -: CYCLE_W];
    rd_reg   = head[XLEN +: REG_ADDR_W];
    rd_data  = head[XLEN-1:0];
    count    = count_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer. Two instances share the stimulus:
// dut (defaults: DEPTH 16, 15-cycle window) and dut4 (DEPTH 4, unbounded).
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        rst, start, wb_en, rd_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] mask;

  logic        rd_valid, overflow, busy, done;
  logic [4:0]  rd_reg;
  logic [31:0] rd_data;
  logic [15:0] rd_cycle;
  logic [4:0]  count;

  logic        q4_valid, q4_overflow, q4_busy, q4_done;
  logic [4:0]  q4_reg;
  logic [31:0] q4_data;
  logic [15:0] q4_cycle;
  logic [2:0]  q4_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_trace_buffer dut (
    .clk(clk), .rst(rst), .start(start), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data),
`ifdef TRACE_FILTER_EN
    .trace_mask(mask),
`endif
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_reg(rd_reg),
    .rd_data(rd_data), .rd_cycle(rd_cycle), .count(count),
    .overflow(overflow), .busy(busy), .done(done)
  );

  wb_trace_buffer #(.DEPTH(4), .RUN_CYCLES(0)) dut4 (
    .clk(clk), .rst(rst), .start(start), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data),
`ifdef TRACE_FILTER_EN
    .trace_mask(mask),
`endif
    .rd_valid(q4_valid), .rd_ready(rd_ready), .rd_reg(q4_reg),
    .rd_data(q4_data), .rd_cycle(q4_cycle), .count(q4_count),
    .overflow(q4_overflow), .busy(q4_busy), .done(q4_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; wb_en = 1'b0; rd_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; wb_en = 1'b0; rd_ready = 1'b0;
    wb_rd = '0; wb_data = '0; mask = 32'hFFFF_FFFF;
    step();
    do_reset();

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_head", {rd_cycle, rd_reg, rd_data}, 0);

    // 1: two writes, FWFT head order, start ignored during RUN
    do_start();
    chk("t1_busy", busy, 1);
    wr(5'd1, 32'd5);                 // cyc 0
    step();                          // cyc 1
    wr(5'd2, 32'hFFFF_FFFD);         // cyc 2
    chk("t1_count", count, 2);
    chk("t1_head0", {rd_cycle, rd_reg, rd_data}, {16'd0, 5'd1, 32'd5});
    rd_ready = 1'b1; step(); rd_ready = 1'b0;   // cyc 3, pop
    chk("t1_head1", {rd_cycle, rd_reg, rd_data}, {16'd2, 5'd2, 32'hFFFF_FFFD});
    chk("t1_count1", count, 1);
    do_start();                      // cyc 4, ignored
    for (int i = 0; i < 9; i++) step();  // cyc 5..13
    chk("t1_busy14", {busy, done}, 2'b10);
    step();                          // cyc 14 is the last window cycle
    chk("t1_done", {busy, done}, 2'b01);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("t1_drained", count, 0);
    wr(5'd6, 32'h66);                // DONE: no capture
    chk("t1_nocap_done", count, 0);

    // 2: write every cycle over the full window
    do_reset();
    do_start();
    for (int k = 0; k < 15; k++) begin
      chk("t2_busy", busy, 1);
      wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'(k);
      step();
    end
    chk("t2_done", done, 1);
    chk("t2_count", count, 15);
    step(); step(); step();
    wb_en = 1'b0;
    chk("t2_count_after", count, 15);
    chk("t2_ovf", overflow, 0);
    rd_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      chk("t2_entry", {rd_cycle, rd_reg, rd_data}, {16'(k), 5'd3, 32'(k)});
      step();
    end
    rd_ready = 1'b0;
    chk("t2_empty", {count, rd_valid}, 0);

    // 3: DEPTH 4 overflow, full push+pop, empty push+pop
    do_reset();
    do_start();
    for (int k = 0; k < 5; k++) wr(5'(k + 1), 32'h100 + 32'(k));  // cyc 0..4
    chk("t3_count", q4_count, 4);
    chk("t3_ovf", q4_overflow, 1);
    chk("t3_head", {q4_cycle, q4_reg, q4_data}, {16'd0, 5'd1, 32'h100});
    rd_ready = 1'b1;
    wr(5'd7, 32'h777);               // cyc 5, push+pop while full
    chk("t3_pp_count", q4_count, 4);
    chk("t3_pp_ovf", q4_overflow, 1);
    chk("t3_pp_head", q4_data, 32'h101);
    step(); chk("t3_h2", q4_data, 32'h102);
    step(); chk("t3_h3", q4_data, 32'h103);
    step(); chk("t3_tail", {q4_cycle, q4_reg, q4_data}, {16'd5, 5'd7, 32'h777});
    step(); chk("t3_empty", {q4_count, q4_valid, q4_data}, 0);
    wr(5'd9, 32'h99);                // cyc 10, push while empty with ready
    rd_ready = 1'b0;
    chk("t3_ep_count", q4_count, 1);
    chk("t3_ep_head", {q4_cycle, q4_reg, q4_data}, {16'd10, 5'd9, 32'h99});
    chk("t3_unbounded", {q4_busy, q4_done}, 2'b10);

    // 4: x0 writes never traced
    do_reset();
    do_start();
    for (int k = 0; k < 3; k++) wr(5'd0, 32'hDEAD);
    chk("t4_count", count, 0);
    chk("t4_valid", rd_valid, 0);

    // 5: reset mid-run
    do_reset();
    do_start();
    for (int k = 0; k < 5; k++) wr(5'd4, 32'(k));  // cyc 0..4
    step(); step();                                 // cyc 5,6 -> at cyc 7
    chk("t5_pre", {count, q4_overflow}, {5'd5, 1'b1});
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_state", {count, busy, done, overflow}, 0);
    chk("t5_q4", {q4_count, q4_overflow, q4_busy}, 0);
    do_start();
    wr(5'd5, 32'h55);
    chk("t5_restamp", {rd_cycle, rd_reg, rd_data, count}, {16'd0, 5'd5, 32'h55, 5'd1});

`ifdef TRACE_FILTER_EN
    // 6: mask selects only x2; bit 0 never enables x0
    do_reset();
    mask = 32'h5;
    do_start();
    wr(5'd0, 32'h10);
    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    wr(5'd3, 32'h33);
    chk("t6_count", count, 1);
    chk("t6_head", {rd_reg, rd_data}, {5'd2, 32'h22});
    mask = 32'hFFFF_FFFF;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
